// File: rtl/d_stage_npc.sv
// d_stage_npc -- decode-stage IF/ID register and next-PC generator.
//
// This block holds the IF/ID pipeline register. It decodes the control transfer
// held in D and resolves it in the same cycle, using the forwarded operands.
// It then presents the next fetch PC to the fetch unit.
// The architecture has one branch delay slot: the instruction after a
// control transfer always executes, so nothing is flushed here.
//
// Ports
//   clk, reset     : clock; synchronous active-high reset
//   stall          : hold the IF/ID register; NPC re-presents PC_F
//   Instr_F, PC_F  : instruction fetched this cycle and its PC
//   rs_D, rt_D     : forwarded GPR operands for Instr_D
//   Instr_D, PC_D  : registered IF/ID contents
//   DS_D           : Instr_D occupies the delay slot of a control transfer
//   NPC            : next PC for the fetch unit
//   Link_D         : PC_D + 8, return address for jal/jalr
//   Taken_D        : Instr_D redirects fetch
module d_stage_npc (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] Instr_F,
    input  logic [31:0] PC_F,
    input  logic [31:0] rs_D,
    input  logic [31:0] rt_D,
    output logic [31:0] Instr_D,
    output logic [31:0] PC_D,
    output logic        DS_D,
    output logic [31:0] NPC,
    output logic [31:0] Link_D,
    output logic        Taken_D
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    localparam logic [31:0] PC_RESET  = 32'h0000_3000;

    // True for every control-transfer encoding, taken or not.
    function automatic logic is_ct(input logic [31:0] ins);
        case (ins[31:26])
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: is_ct = 1'b1;
            OP_REGIMM:  is_ct = (ins[20:16] == RT_BLTZ) || (ins[20:16] == RT_BGEZ);
            OP_SPECIAL: is_ct = (ins[5:0] == FN_JR) || (ins[5:0] == FN_JALR);
            default:    is_ct = 1'b0;
        endcase
    endfunction

    // IF -> ID register. DS_D records whether the instruction leaving D was
    // a control transfer, so the incoming one is its delay slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            Instr_D <= 32'h0000_0000;
            PC_D    <= PC_RESET;
            DS_D    <= 1'b0;
        end else if (!stall) begin
            Instr_D <= Instr_F;
            PC_D    <= PC_F;
            DS_D    <= is_ct(Instr_D);
        end
    end

    // ID: resolve the control transfer held in D.
    logic        [5:0]  opcode;
    logic        [5:0]  funct;
    logic        [4:0]  rt_field;
    logic signed [31:0] rs_s;
    logic signed [31:0] rt_s;
    logic        [31:0] br_target;
    logic        [31:0] j_target;
    logic        [31:0] target;

    assign opcode    = Instr_D[31:26];
    assign funct     = Instr_D[5:0];
    assign rt_field  = Instr_D[20:16];
    assign rs_s      = rs_D;
    assign rt_s      = rt_D;
    assign br_target = PC_D + 32'd4 + {{14{Instr_D[15]}}, Instr_D[15:0], 2'b00};
    assign j_target  = {PC_D[31:28], Instr_D[25:0], 2'b00};

    always_comb begin
        Taken_D = 1'b0;
        target  = br_target;
        case (opcode)
            OP_BEQ:  Taken_D = (rs_s == rt_s);
            OP_BNE:  Taken_D = (rs_s != rt_s);
            OP_BLEZ: Taken_D = (rs_s <= 32'sd0);
            OP_BGTZ: Taken_D = (rs_s >  32'sd0);
            OP_REGIMM: begin
                if (rt_field == RT_BLTZ)      Taken_D = (rs_s <  32'sd0);
                else if (rt_field == RT_BGEZ) Taken_D = (rs_s >= 32'sd0);
            end
            OP_J, OP_JAL: begin
                Taken_D = 1'b1;
                target  = j_target;
            end
            OP_SPECIAL: begin
                if (funct == FN_JR || funct == FN_JALR) begin
                    Taken_D = 1'b1;
                    target  = rs_D;
                end
            end
            default: ;
        endcase
    end

    // Stall wins so fetch re-presents the held PC; a transfer resolved
    // during the stall redirects on the first free cycle.
    assign NPC    = stall ? PC_F : (Taken_D ? target : PC_F + 32'd4);
    assign Link_D = PC_D + 32'd8;

endmodule

// File: doc/d_stage_npc.md
D_STAGE_NPC -- requirements
Module: d_stage_npc

Interface
REQ-001 SHALL have ports clk (in, 1, clock) and reset (in, 1; synchronous, active-high).
REQ-002 SHALL have stall (in, 1): hold IF/ID contents and PC.
REQ-003 SHALL have Instr_F (in, 32): instruction fetched this cycle.
REQ-004 SHALL have PC_F (in, 32): PC of Instr_F.
REQ-005 SHALL have rs_D (in, 32) and rt_D (in, 32): forwarded GPR values for Instr_D.
REQ-006 SHALL have Instr_D (out, 32) and PC_D (out, 32): registered IF/ID contents.
REQ-007 SHALL have DS_D (out, 1): high when Instr_D sits in the delay slot of a control transfer.
REQ-008 SHALL have NPC (out, 32): next PC presented to the fetch unit.
REQ-009 SHALL have Link_D (out, 32): PC_D+8, the return address for jal/jalr.
REQ-010 SHALL have Taken_D (out, 1): Instr_D redirects fetch.

Function
REQ-011 SHALL update Instr_D, PC_D and DS_D on the posedge when reset=0 and stall=0: Instr_D<=Instr_F, PC_D<=PC_F, DS_D<=IsCT(Instr_D).
REQ-012 SHALL hold Instr_D, PC_D and DS_D unchanged on the posedge when stall=1 and reset=0.
REQ-013 SHALL define IsCT as: beq, bne, blez, bgtz, bltz, bgez, j, jal, jr, jalr; any other encoding is 0.
REQ-014 SHALL decode opcodes: beq 000100, bne 000101, blez 000110, bgtz 000111, j 000010, jal 000011.
REQ-015 SHALL decode REGIMM (opcode 000001) by rt field: rt=00000 is bltz, rt=00001 is bgez; other rt values are non-CT.
REQ-016 SHALL decode SPECIAL (opcode 000000) by funct: 001000 is jr, 001001 is jalr.
REQ-017 SHALL evaluate branch conditions on 32-bit signed values.
- beq: rs==rt. bne: rs!=rt.
- blez: rs<=0. bgtz: rs>0.
- bltz: rs<0. bgez: rs>=0.
REQ-018 SHALL form the branch target as PC_D + 4 + (signext(imm16)<<2), 32-bit, wrapping modulo 2^32.
REQ-019 SHALL form the j/jal target as {PC_D[31:28], instr_index[25:0], 2'b00}.
REQ-020 SHALL form the jr/jalr target as rs_D.
REQ-021 SHALL compute NPC combinationally, highest priority first:
- stall=1: NPC=PC_F.
- Taken_D=1: NPC=target.
- otherwise: NPC=PC_F+4.
REQ-022 SHALL assert Taken_D for j, jal, jr and jalr unconditionally, and for a branch iff its condition holds.
REQ-023 SHALL let the delay-slot instruction (at PC_D+4) proceed down the pipeline; there is no flush and no squash.
REQ-024 SHALL compute Link_D = PC_D + 8 for every instruction, wrapping modulo 2^32.
REQ-025 SHALL compute Taken_D from the held Instr_D while stall=1, but NPC SHALL still equal PC_F.
REQ-026 SHALL add no extra latency: NPC reflects Instr_D in the same cycle Instr_D is valid.

Reset
REQ-027 SHALL, on a posedge with reset=1, set Instr_D=32'h0000_0000 (nop), PC_D=32'h0000_3000 and DS_D=0.
REQ-028 SHALL give reset priority over stall.
REQ-029 SHALL discard any in-flight control transfer when reset is asserted mid-operation; the nop in D yields NPC=PC_F+4 when stall=0.

Verification
REQ-030 SHALL cover reset: assert reset for 1 cycle with stall=1 -> Instr_D=0, PC_D=0x3000, DS_D=0, Taken_D=0; with stall=0 and PC_F=0x3000, NPC=0x3004.
REQ-031 SHALL cover taken beq: PC_D=0x3008, Instr_D=beq with imm=0xFFFE, rs_D=rt_D=5 -> Taken_D=1, NPC=0x3004; next cycle DS_D=1.
REQ-032 SHALL cover not-taken bgez: rs_D=0x8000_0000, PC_F=0x3010 -> Taken_D=0, NPC=0x3014; DS_D is still set next cycle.
REQ-033 SHALL cover jal: PC_D=0x3020, index=0x0000C10 -> NPC=0x0000_3040, Link_D=0x3028; jr with rs_D=0x3028 -> NPC=0x3028.
REQ-034 SHALL cover stall: stall=1 for 3 cycles with a taken bne in D -> Instr_D/PC_D/DS_D constant and NPC=PC_F; after release, NPC=target for one cycle.
REQ-035 SHALL cover REGIMM rt=00010: Instr_D with opcode 000001 -> Taken_D=0, NPC=PC_F+4, and DS_D=0 next cycle.
